// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep unit.
//   - gate mode encodings (GM_*); codes 6/7 fall through to NOR
//   - FSM state type
//   - reduce_gate(): reduction of the low 'width' bits of a vector under a mode
package gate_pkg;

  localparam int MAX_N = 16;

  localparam logic [2:0] GM_AND  = 3'd0;
  localparam logic [2:0] GM_OR   = 3'd1;
  localparam logic [2:0] GM_NAND = 3'd2;
  localparam logic [2:0] GM_NOR  = 3'd3;
  localparam logic [2:0] GM_XOR  = 3'd4;
  localparam logic [2:0] GM_XNOR = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Bits at or above 'width' are ignored, so the caller may zero-extend
  // any narrower operand into the MAX_N-wide vector.
  function automatic logic reduce_gate(input logic [2:0] mode,
                                       input logic [MAX_N-1:0] vec,
                                       input int width);
    logic r_and, r_or, r_xor, r;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < width) begin
        r_and = r_and & vec[i];
        r_or  = r_or  | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (mode)
      GM_AND:  r = r_and;
      GM_OR:   r = r_or;
      GM_NAND: r = ~r_and;
      GM_XOR:  r = r_xor;
      GM_XNOR: r = ~r_xor;
      default: r = ~r_or;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_eval.sv
// Combinational gate evaluator.
//   pattern : N-bit input vector
//   mode    : gate select (gate_pkg GM_* encoding)
//   res     : N-input reduction of pattern
//   pair    : bit j = same gate over pattern[2j+1:2j]
module gate_eval
  import gate_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]   pattern,
  input  logic [2:0]     mode,
  output logic           res,
  output logic [N/2-1:0] pair
);

  logic [MAX_N-1:0] vec_ext;

  always_comb begin
    vec_ext          = '0;
    vec_ext[N-1:0]   = pattern;
  end

  assign res = reduce_gate(mode, vec_ext, N);

  for (genvar j = 0; j < N/2; j++) begin : g_pair
    logic [MAX_N-1:0] pv;
    assign pv      = {{(MAX_N-2){1'b0}}, pattern[2*j+1:2*j]};
    assign pair[j] = reduce_gate(mode, pv, 2);
  end

endmodule

// File: rtl/gate_sweep_unit.sv
// Self-sequencing gate sweep: walks every N-bit pattern, holding each for
// HOLD cycles, registers the gate result in the last hold cycle and tallies
// the patterns that evaluate to 1.
//   clk, rst_n   : clock / async active-low reset
//   start, abort : sweep control (abort wins over start)
//   mode         : gate select, latched when a sweep starts
//   pattern      : pattern currently applied
//   res_valid    : one-cycle pulse qualifying res_pattern/res_out/pair_out
//   ones_count   : number of results equal to 1 in this sweep (saturating)
//   busy, done   : sweep running / one-cycle completion pulse
module gate_sweep_unit
  import gate_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [2:0]     mode,
  output logic [N-1:0]   pattern,
  output logic           res_valid,
  output logic [N-1:0]   res_pattern,
  output logic           res_out,
  output logic [N/2-1:0] pair_out,
  output logic [N:0]     ones_count,
  output logic           busy,
  output logic           done
);

  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N:0]    ONES_MAX  = {1'b1, {N{1'b0}}};

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [N-1:0]     pattern_q, pattern_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [N:0]       ones_q, ones_d;
  logic             res_valid_q, res_valid_d;
  logic             res_out_q, res_out_d;
  logic [N-1:0]     res_pattern_q, res_pattern_d;
  logic [N/2-1:0]   pair_q, pair_d;

  logic             eval_res;
  logic [N/2-1:0]   eval_pair;
  logic             last_hold, last_pat;

  gate_eval #(.N(N)) u_eval (
    .pattern (pattern_q),
    .mode    (mode_q),
    .res     (eval_res),
    .pair    (eval_pair)
  );

  assign last_hold = (hold_q == HOLD_LAST);
  assign last_pat  = &pattern_q;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    pattern_d     = pattern_q;
    hold_d        = hold_q;
    ones_d        = ones_q;
    res_valid_d   = 1'b0;
    res_out_d     = res_out_q;
    res_pattern_d = res_pattern_q;
    pair_d        = pair_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = RUN;
          mode_d    = mode;
          pattern_d = '0;
          hold_d    = '0;
          ones_d    = '0;
        end
      end
      RUN: begin
        if (abort) begin
          // Pending result for this edge is dropped along with the sweep.
          state_d = IDLE;
        end else if (last_hold) begin
          hold_d        = '0;
          res_valid_d   = 1'b1;
          res_out_d     = eval_res;
          res_pattern_d = pattern_q;
          pair_d        = eval_pair;
          if (eval_res && (ones_q != ONES_MAX)) ones_d = ones_q + 1'b1;
          // Final pattern: stay on it rather than wrapping to 0.
          if (last_pat) state_d   = DONE;
          else          pattern_d = pattern_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_q        <= GM_NOR;
      pattern_q     <= '0;
      hold_q        <= '0;
      ones_q        <= '0;
      res_valid_q   <= 1'b0;
      res_out_q     <= 1'b0;
      res_pattern_q <= '0;
      pair_q        <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      pattern_q     <= pattern_d;
      hold_q        <= hold_d;
      ones_q        <= ones_d;
      res_valid_q   <= res_valid_d;
      res_out_q     <= res_out_d;
      res_pattern_q <= res_pattern_d;
      pair_q        <= pair_d;
    end
  end

  assign pattern     = pattern_q;
  assign res_valid   = res_valid_q;
  assign res_pattern = res_pattern_q;
  assign res_out     = res_out_q;
  assign pair_out    = pair_q;
  assign ones_count  = ones_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_gate_sweep_unit.sv
module tb_gate_sweep_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // N=4, HOLD=2 instance
  logic       start4, abort4;
  logic [2:0] mode4;
  logic [3:0] pattern4, res_pattern4;
  logic       res_valid4, res_out4, busy4, done4;
  logic [1:0] pair4;
  logic [4:0] ones4;

  gate_sweep_unit #(.N(4), .HOLD(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .mode(mode4),
    .pattern(pattern4), .res_valid(res_valid4), .res_pattern(res_pattern4),
    .res_out(res_out4), .pair_out(pair4), .ones_count(ones4),
    .busy(busy4), .done(done4)
  );

  // N=8, HOLD=1 instance
  logic       start8, abort8;
  logic [2:0] mode8;
  logic [7:0] pattern8, res_pattern8;
  logic       res_valid8, res_out8, busy8, done8;
  logic [3:0] pair8;
  logic [8:0] ones8;

  gate_sweep_unit #(.N(8), .HOLD(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .mode(mode8),
    .pattern(pattern8), .res_valid(res_valid8), .res_pattern(res_pattern8),
    .res_out(res_out8), .pair_out(pair8), .ones_count(ones8),
    .busy(busy8), .done(done8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] pat;
    logic       res;
    logic [1:0] pair;
    logic [4:0] ones;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  logic [2:0] cur_mode = 3'd3;
  int last_c0 = 0;

  // Reference gate from the count of ones among w inputs.
  function automatic logic mdl(input logic [2:0] m, input int c, input int w);
    case (m)
      3'd0:    return c == w;
      3'd1:    return c != 0;
      3'd2:    return c != w;
      3'd4:    return (c % 2) == 1;
      3'd5:    return (c % 2) == 0;
      default: return c == 0;
    endcase
  endfunction

  // Called just after a negedge; start is sampled at the next posedge (edge c0).
  task automatic issue_start4(input logic [2:0] m, input int npush, input bit hold_start);
    int c0, acc;
    exp_t e;
    logic [3:0] p;
    c0 = cyc + 1;
    acc = 0;
    for (int k = 0; k < npush; k++) begin
      p = 4'(k);
      e.pat     = p;
      e.res     = mdl(m, $countones(p), 4);
      e.pair[0] = mdl(m, $countones(p[1:0]), 2);
      e.pair[1] = mdl(m, $countones(p[3:2]), 2);
      if (e.res) acc++;
      e.ones    = 5'(acc);
      e.last    = (k == 15);
      e.cyc     = c0 + (k + 1) * 2;
      sbq.push_back(e);
    end
    last_c0  = c0;
    cur_mode = m;
    mode4    = m;
    start4   = 1'b1;
    @(negedge clk);
    if (!hold_start) start4 = 1'b0;
  endtask

  task automatic wait_done4();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done4) begin
        start4 = 1'b0;
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within 100 cycles");
    end else begin
      chk("pattern_at_done", 32'(pattern4), 32'hF);
    end
    @(negedge clk);
    chk("queue_drained", 32'(sbq.size()), 0);
    chk("busy_after_done", 32'(busy4), 0);
  endtask

  // Scoreboard monitor for the N=4 instance.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid4) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_res_valid: pattern %0h with none expected", res_pattern4);
        end else begin
          me = sbq.pop_front();
          chk("res_pattern", 32'(res_pattern4), 32'(me.pat));
          chk("res_out", 32'(res_out4), 32'(me.res));
          chk("pair_out", 32'(pair4), 32'(me.pair));
          chk("ones_count", 32'(ones4), 32'(me.ones));
          chk("done_with_result", 32'(done4), 32'(me.last));
          chk("res_cycle", cyc, me.cyc);
          if (cur_mode == 3'd3 && me.pat == 4'b1100)
            chk("pair_1100_nor", 32'(pair4), 32'b01);
        end
      end else if (done4) begin
        n_cmp++; n_bad++;
        $display("FAIL done_without_result: done high with res_valid low");
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] mode_tab [6] = '{3'd3, 3'd0, 3'd1, 3'd4, 3'd5, 3'd7};
  int         ones_tab [6] = '{1, 1, 15, 8, 8, 1};

  initial begin
    int nb, nv, nd, first_v, last_v, dc, c0;
    rst_n = 1'b0;
    start4 = 0; abort4 = 0; mode4 = 3'd3;
    start8 = 0; abort8 = 0; mode8 = 3'd4;
    repeat (2) @(negedge clk);
    chk("reset_outputs4", 32'({pattern4, res_valid4, res_pattern4, res_out4, pair4, ones4, busy4, done4}), 0);
    chk("reset_outputs8", 32'({pattern8, res_valid8, res_out8, ones8, busy8, done8}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweeps, one per mode, with hand-computed final tallies.
    for (int t = 0; t < 6; t++) begin
      issue_start4(mode_tab[t], 16, 0);
      wait_done4();
      chk("final_ones", 32'(ones4), 32'(ones_tab[t]));
    end

    // Abort in the final hold cycle of pattern 6: its result must not appear.
    issue_start4(3'd3, 6, 0);
    while (cyc < last_c0 + 13) @(negedge clk);
    chk("pattern_at_abort", 32'(pattern4), 32'd6);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_done", 32'(done4), 0);
    chk("abort_ones", 32'(ones4), 1);
    repeat (4) @(negedge clk);
    chk("abort_queue", 32'(sbq.size()), 0);
    // Restart after abort begins at pattern 0.
    issue_start4(3'd3, 16, 0);
    wait_done4();

    // start held through RUN plus a mode change mid-sweep.
    issue_start4(3'd3, 16, 1);
    repeat (5) @(negedge clk);
    mode4 = 3'd0;
    wait_done4();
    chk("held_start_ones", 32'(ones4), 1);
    repeat (5) @(negedge clk);
    chk("held_start_no_restart", 32'(busy4), 0);

    // Asynchronous reset mid-sweep.
    issue_start4(3'd1, 16, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("midsweep_reset", 32'({pattern4, res_valid4, res_pattern4, res_out4, pair4, ones4, busy4, done4}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 32'(busy4), 0);

    // N=8, HOLD=1, XOR.
    c0 = cyc + 1;
    mode8 = 3'd4;
    start8 = 1'b1;
    nb = 0; nv = 0; nd = 0; first_v = -1; last_v = -1; dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
      if (busy8) nb++;
      if (res_valid8) begin
        nv++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (res_out8 !== ^res_pattern8) begin
          n_cmp++; n_bad++;
          $display("FAIL n8_res_out: pattern %0h got %0b", res_pattern8, res_out8);
        end
      end
      if (done8) begin
        nd++;
        dc = cyc;
      end
    end
    chk("n8_valid_count", nv, 256);
    chk("n8_first_valid", first_v, c0 + 1);
    chk("n8_last_valid", last_v, c0 + 256);
    chk("n8_busy_cycles", nb, 256);
    chk("n8_done_count", nd, 1);
    chk("n8_done_cycle", dc, c0 + 256);
    chk("n8_ones", 32'(ones8), 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
